// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record path.
package aud_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int ADDR_W_DEF = 20;

  // Recorder states. WAIT, SHIFT and WRITE are the "busy" states.
  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SHIFT,
    WRITE,
    PAUSE
  } rec_state_t;

endpackage

// File: rtl/i2s_rx_shift.sv
// Left-channel I2S deserializer: LRCK fall detector, bit counter and
// MSB-first shift register. While arm is high, one bit is taken per clock.
// When arm is low, the counter is cleared, so a dropped partial sample never
// leaks into the next one. valid/sample are combinational: they mark the
// edge that captures the 16th bit, so the caller can register the finished
// sample on that same edge.
module i2s_rx_shift
  import aud_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                lrck,
  input  logic                din,
  output logic                fall,
  output logic                valid,
  output logic [SAMPLE_W-1:0] sample
);

  logic                prev_lrck;
  logic [3:0]          bitcnt;
  logic [SAMPLE_W-1:0] sreg;

  // Track LRCK history; shift and count only while armed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_lrck <= 1'b0;
      bitcnt    <= 4'd0;
      sreg      <= '0;
    end else begin
      prev_lrck <= lrck;
      if (arm) begin
        sreg   <= {sreg[SAMPLE_W-2:0], din};
        bitcnt <= bitcnt + 4'd1;
      end else begin
        bitcnt <= 4'd0;
      end
    end
  end

  // The fall cycle is the I2S delay slot; the first data bit follows it.
  assign fall   = prev_lrck & ~lrck;
  assign valid  = arm && (bitcnt == 4'd15);
  assign sample = {sreg[SAMPLE_W-2:0], din};

endmodule

// File: rtl/aud_record_ctrl.sv
// Record controller: captures left-channel I2S samples and writes them to
// SRAM from address 0 upward. It reports how many samples are valid, and
// whether the recording stopped because the last address was written.
// Handshake: o_sram_we is a single-cycle strobe. o_sram_addr and o_sram_data
// are valid in the same cycle. The arbiter takes the write with no
// back-pressure.
module aud_record_ctrl
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_adclrck,
  input  logic                i_adcdat,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [SAMPLE_W-1:0] o_sram_data,
  output logic                o_sram_we,
  output logic [ADDR_W-1:0]   o_rec_len,
  output logic                o_busy,
  output logic                o_full
);

  rec_state_t          state;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   len_next;
  logic                arm;
  logic                fall;
  logic                valid;
  logic [SAMPLE_W-1:0] sample;

  assign arm = (state == SHIFT);

  i2s_rx_shift u_rx (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .arm    (arm),
    .lrck   (i_adclrck),
    .din    (i_adcdat),
    .fall   (fall),
    .valid  (valid),
    .sample (sample)
  );

  // Length after this write. It is clamped so a full 2^ADDR_W recording
  // never reads back as zero.
  assign len_next = (addr == {ADDR_W{1'b1}}) ? addr : addr + ADDR_W'(1);

  assign o_busy = (state == WAIT) || (state == SHIFT) || (state == WRITE);

  // Recorder FSM with address pointer, length and registered SRAM outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      o_sram_addr <= '0;
      o_sram_data <= '0;
      o_sram_we   <= 1'b0;
      o_rec_len   <= '0;
      o_full      <= 1'b0;
    end else begin
      o_sram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr      <= '0;
            o_rec_len <= '0;
            o_full    <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (i_stop)       state <= IDLE;
          else if (i_pause) state <= PAUSE;
          else if (fall)    state <= SHIFT;
        end
        SHIFT: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_pause) begin
            state <= PAUSE;
          end else if (valid) begin
            state       <= WRITE;
            o_sram_we   <= 1'b1;
            o_sram_addr <= addr;
            o_sram_data <= sample;
          end
        end
        WRITE: begin
          // The write always completes. Commands take effect after it.
          o_rec_len <= len_next;
          if (addr == MAX_ADDR) begin
            o_full <= 1'b1;
            state  <= IDLE;
          end else begin
            addr <= addr + ADDR_W'(1);
            if (i_stop)       state <= IDLE;
            else if (i_pause) state <= PAUSE;
            else              state <= WAIT;
          end
        end
        PAUSE: begin
          if (i_stop)       state <= IDLE;
          else if (i_start) state <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_record_ctrl.sv
// Directed bench for aud_record_ctrl, built with a small last address (3).
module tb_aud_record_ctrl;

  localparam int            AW   = 20;
  localparam logic [AW-1:0] MAXA = 20'd3;

  // ---------------- clock / reset ----------------
  logic          clk;
  logic          i_rst_n;
  logic          i_start, i_pause, i_stop;
  logic          i_adclrck, i_adcdat;
  logic [AW-1:0] o_sram_addr;
  logic [15:0]   o_sram_data;
  logic          o_sram_we;
  logic [AW-1:0] o_rec_len;
  logic          o_busy;
  logic          o_full;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  aud_record_ctrl #(.ADDR_W(AW), .MAX_ADDR(MAXA)) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_pause     (i_pause),
    .i_stop      (i_stop),
    .i_adclrck   (i_adclrck),
    .i_adcdat    (i_adcdat),
    .o_sram_addr (o_sram_addr),
    .o_sram_data (o_sram_data),
    .o_sram_we   (o_sram_we),
    .o_rec_len   (o_rec_len),
    .o_busy      (o_busy),
    .o_full      (o_full)
  );

  // ---------------- scoreboard ----------------
  logic [15:0]   exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];
  logic [15:0]   wr_data_q[$];
  logic [AW-1:0] wr_addr_q[$];
  int            wr_cyc_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Record every SRAM write, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_sram_we) begin
      wr_data_q.push_back(o_sram_data);
      wr_addr_q.push_back(o_sram_addr);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_nwr"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && wr_data_q.size() > 0) begin
      chk({tag, "_data"}, 32'(wr_data_q.pop_front()), 32'(exp_q.pop_front()));
      chk({tag, "_addr"}, 32'(wr_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
      chk({tag, "_lat"},  32'(wr_cyc_q.pop_front()),  32'(exp_cyc_q.pop_front()));
    end
    exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
    wr_data_q.delete(); wr_addr_q.delete(); wr_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // cmd = {stop, pause, start}; pulses last exactly one cycle.
  task automatic tick(input logic l, input logic d, input logic [2:0] cmd);
    @(negedge clk);
    i_adclrck = l;
    i_adcdat  = d;
    {i_stop, i_pause, i_start} = cmd;
  endtask

  task automatic idle(input int n, input logic [2:0] cmd);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, (i == 0) ? cmd : 3'b000);
  endtask

  task automatic half(input logic l, input logic [15:0] w, input int from, input int cmd_bit,
                      input logic [2:0] cmd);
    for (int i = from; i < 32; i++) begin
      logic d;
      d = (i >= 1 && i <= 16) ? w[16 - i] : 1'($urandom_range(0, 1));
      tick(l, d, (i == cmd_bit) ? cmd : 3'b000);
    end
  endtask

  // One LRCK frame: left half (index 0 is the delay slot), then right half.
  task automatic send_frame(input logic [15:0] left, input logic [15:0] right,
                            input logic exp_wr, input logic [AW-1:0] exp_addr,
                            input int cmd_bit, input logic [2:0] cmd);
    for (int i = 0; i < 32; i++) begin
      logic d;
      d = (i >= 1 && i <= 16) ? left[16 - i] : 1'($urandom_range(0, 1));
      tick(1'b0, d, (i == cmd_bit) ? cmd : 3'b000);
      if (i == 0 && exp_wr) begin
        exp_q.push_back(left);
        exp_addr_q.push_back(exp_addr);
        exp_cyc_q.push_back(cyc + 17);
      end
    end
    half(1'b1, right, 0, -1, 3'b000);
  endtask

  localparam logic [2:0] C_START = 3'b001;
  localparam logic [2:0] C_PAUSE = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b100;

  // ---------------- stimulus ----------------
  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    i_adclrck = 1'b1; i_adcdat = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_data", 32'(o_sram_data), 32'd0);
    chk("rst_we",   32'(o_sram_we),   32'd0);
    chk("rst_len",  32'(o_rec_len),   32'd0);
    chk("rst_busy", 32'(o_busy),      32'd0);
    chk("rst_full", 32'(o_full),      32'd0);
    i_rst_n = 1'b1;
    idle(3, 3'b000);

    // Basic capture
    idle(2, C_START);
    chk("t1_busy", 32'(o_busy), 32'd1);
    send_frame(16'hA5C3, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    idle(2, 3'b000);
    drain("t1");
    chk("t1_len", 32'(o_rec_len), 32'd1);

    // Three frames, right channel never written
    idle(2, C_STOP);
    chk("t2_stop_busy", 32'(o_busy), 32'd0);
    idle(2, C_START);
    send_frame(16'h0001, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    send_frame(16'h8000, 16'h1234, 1'b1, 20'd1, -1, 3'b000);
    send_frame(16'hFFFF, 16'h1234, 1'b1, 20'd2, -1, 3'b000);
    idle(2, 3'b000);
    drain("t2");
    chk("t2_len", 32'(o_rec_len), 32'd3);

    // Pause mid-sample, resume on the next frame
    idle(2, C_STOP);
    idle(2, C_START);
    send_frame(16'h5A5A, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    send_frame(16'h1111, 16'h1234, 1'b0, 20'd0, 9, C_PAUSE);
    chk("t3_pause_busy", 32'(o_busy), 32'd0);
    chk("t3_pause_len",  32'(o_rec_len), 32'd1);
    idle(2, C_START);
    send_frame(16'h2222, 16'h1234, 1'b1, 20'd1, -1, 3'b000);
    idle(2, 3'b000);
    drain("t3");
    chk("t3_len", 32'(o_rec_len), 32'd2);

    // Fill to the last address
    idle(2, C_STOP);
    idle(2, C_START);
    send_frame(16'h0A0A, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    send_frame(16'h0B0B, 16'h1234, 1'b1, 20'd1, -1, 3'b000);
    send_frame(16'h0C0C, 16'h1234, 1'b1, 20'd2, -1, 3'b000);
    send_frame(16'h0D0D, 16'h1234, 1'b1, 20'd3, -1, 3'b000);
    chk("t4_full", 32'(o_full),    32'd1);
    chk("t4_len",  32'(o_rec_len), 32'd4);
    chk("t4_busy", 32'(o_busy),    32'd0);
    send_frame(16'h0E0E, 16'h1234, 1'b0, 20'd0, -1, 3'b000);
    idle(2, 3'b000);
    drain("t4");
    chk("t4_full_hold", 32'(o_full),      32'd1);
    chk("t4_addr_hold", 32'(o_sram_addr), 32'd3);
    chk("t4_data_hold", 32'(o_sram_data), 32'h0D0D);

    // Stop+pause together during SHIFT, then a command during WRITE
    idle(2, C_START);
    chk("t5_full_clr", 32'(o_full),    32'd0);
    chk("t5_len_clr",  32'(o_rec_len), 32'd0);
    send_frame(16'h3C3C, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    send_frame(16'h4444, 16'h1234, 1'b0, 20'd0, 5, C_STOP | C_PAUSE);
    chk("t5_sp_busy", 32'(o_busy),    32'd0);
    chk("t5_sp_len",  32'(o_rec_len), 32'd1);
    idle(2, C_START);
    chk("t5_restart_len", 32'(o_rec_len), 32'd0);
    send_frame(16'h6006, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    send_frame(16'h7117, 16'h1234, 1'b1, 20'd1, 17, C_PAUSE);
    chk("t5_wrpause_busy", 32'(o_busy),    32'd0);
    chk("t5_wrpause_len",  32'(o_rec_len), 32'd2);
    idle(2, C_START);
    send_frame(16'h8228, 16'h1234, 1'b1, 20'd2, -1, 3'b000);
    idle(2, 3'b000);
    drain("t5");
    chk("t5_len", 32'(o_rec_len), 32'd3);

    // Asynchronous reset at bit 10 of frame 2
    idle(2, C_STOP);
    idle(2, C_START);
    send_frame(16'hBEEF, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    tick(1'b0, 1'b0, 3'b000);
    for (int i = 1; i <= 10; i++) begin
      logic [15:0] w;
      w = 16'hCAFE;
      tick(1'b0, w[16 - i], 3'b000);
    end
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_addr", 32'(o_sram_addr), 32'd0);
    chk("t6_data", 32'(o_sram_data), 32'd0);
    chk("t6_we",   32'(o_sram_we),   32'd0);
    chk("t6_len",  32'(o_rec_len),   32'd0);
    chk("t6_busy", 32'(o_busy),      32'd0);
    chk("t6_full", 32'(o_full),      32'd0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    half(1'b0, 16'h0000, 11, -1, 3'b000);
    half(1'b1, 16'h1234, 0, -1, 3'b000);
    send_frame(16'h7777, 16'h1234, 1'b0, 20'd0, -1, 3'b000);
    chk("t6_post_busy", 32'(o_busy),    32'd0);
    chk("t6_post_len",  32'(o_rec_len), 32'd0);
    idle(2, C_START);
    send_frame(16'h4242, 16'h1234, 1'b1, 20'd0, -1, 3'b000);
    idle(2, 3'b000);
    drain("t6");
    chk("t6_final_len", 32'(o_rec_len), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
